// File: rtl/multdiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int ITER_COUNT = MD_WIDTH;

    localparam logic [MD_WIDTH-1:0] INT_MIN = {1'b1, {(MD_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

endpackage

// File: rtl/addsub_33bit.sv
// Add/subtract with carry-out; carry is the no-borrow flag when subtracting.
module addsub_33bit #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_full;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
    assign o_sum   = w_full[WIDTH-1:0];
    assign o_carry = w_full[WIDTH];

endmodule

// File: rtl/multdiv_unit.sv
// Radix-2 signed multiply/divide: one bit per clock on magnitudes, sign applied at the end.
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV
// RUN   | DWIDTH iteration edges, then one finalize edge
// DONE  | result valid, data_resultRDY pulse
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int DWIDTH = MD_WIDTH,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] data_operandA,
    input  logic [DWIDTH-1:0] data_operandB,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    output logic [DWIDTH-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);

    localparam logic [2*DWIDTH-1:0] LIM = {{DWIDTH{1'b0}}, 1'b1, {(DWIDTH-1){1'b0}}};

    state_t              r_state, w_state_nxt;
    op_t                 r_op;
    logic                r_neg;
    logic [CNT_W-1:0]    r_cnt;
    logic [DWIDTH:0]     r_mag_a, r_mag_b;
    logic [DWIDTH:0]     r_hi;
    logic [DWIDTH-1:0]   r_lo;
    logic [DWIDTH-1:0]   r_result;
    logic                r_exc, r_rdy, r_busy;

    logic                w_start, w_last;
    logic [DWIDTH:0]     w_mag_a, w_mag_b;
    logic [DWIDTH:0]     w_add_a, w_add_b, w_sum;
    logic                w_add_sub, w_carry;
    logic [2*DWIDTH-1:0] w_prod;
    logic [DWIDTH-1:0]   w_fin_res;
    logic                w_fin_exc;

    assign w_start = (r_state == IDLE) && (ctrl_MULT || ctrl_DIV);
    assign w_last  = (r_state == RUN) && (r_cnt == CNT_W'(ITER_COUNT));

    // Extra magnitude bit keeps |INT_MIN| = 2^(DWIDTH-1) representable.
    always_comb begin
        w_mag_a = {1'b0, data_operandA};
        w_mag_b = {1'b0, data_operandB};
        if (data_operandA[DWIDTH-1]) w_mag_a = ~{1'b1, data_operandA} + 1'b1;
        if (data_operandB[DWIDTH-1]) w_mag_b = ~{1'b1, data_operandB} + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (ctrl_MULT || ctrl_DIV) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // One adder shared by the multiply add, the divide trial subtract and the final negate.
    always_comb begin
        w_add_a   = r_hi;
        w_add_b   = r_mag_a;
        w_add_sub = 1'b0;
        if (w_last) begin
            w_add_a   = '0;
            w_add_b   = {1'b0, r_lo};
            w_add_sub = 1'b1;
        end else if (r_op == OP_DIV) begin
            w_add_a   = {r_hi[DWIDTH-1:0], r_lo[DWIDTH-1]};
            w_add_b   = r_mag_b;
            w_add_sub = 1'b1;
        end
    end

    addsub_33bit #(.WIDTH(DWIDTH + 1)) u_addsub (
        .i_a     (w_add_a),
        .i_b     (w_add_b),
        .i_sub   (w_add_sub),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Product magnitude sits in {r_hi, r_lo}; quotient magnitude sits in r_lo.
    always_comb begin
        w_prod    = {r_hi[DWIDTH-1:0], r_lo};
        w_fin_res = r_neg ? w_sum[DWIDTH-1:0] : r_lo;
        w_fin_exc = 1'b0;
        if (r_op == OP_MUL) begin
            w_fin_exc = r_neg ? (w_prod > LIM) : (w_prod >= LIM);
        end else if (r_mag_b == '0) begin
            w_fin_res = '0;
            w_fin_exc = 1'b1;
        end else begin
            w_fin_exc = ~r_neg & r_lo[DWIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_op    <= ctrl_MULT ? OP_MUL : OP_DIV;
                    r_neg   <= data_operandA[DWIDTH-1] ^ data_operandB[DWIDTH-1];
                    r_mag_a <= w_mag_a;
                    r_mag_b <= w_mag_b;
                    r_hi    <= '0;
                    r_lo    <= ctrl_MULT ? w_mag_b[DWIDTH-1:0] : w_mag_a[DWIDTH-1:0];
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
                RUN: if (w_last) begin
                    r_result <= w_fin_res;
                    r_exc    <= w_fin_exc;
                    r_rdy    <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op == OP_MUL) begin
                        if (r_lo[0]) {r_hi, r_lo} <= {w_carry, w_sum, r_lo[DWIDTH-1:1]};
                        else         {r_hi, r_lo} <= {1'b0, r_hi, r_lo[DWIDTH-1:1]};
                    end else begin
                        r_hi <= w_carry ? w_sum : {r_hi[DWIDTH-1:0], r_lo[DWIDTH-1]};
                        r_lo <= {r_lo[DWIDTH-2:0], w_carry};
                    end
                end
                DONE: begin
                    r_rdy  <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench: stimulus queues expected results, a monitor checks each RDY pulse.
module tb_multdiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_a, op_b;
    logic        c_mult, c_div;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    multdiv_unit dut (
        .clk            (clk),
        .rst            (rst),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .ctrl_MULT      (c_mult),
        .ctrl_DIV       (c_div),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, expv);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, act, expv);
        end
    endtask

    // Monitor: every RDY pulse must match the oldest expectation, including its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_resultRDY === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy: got pulse with result %h at cycle %0d, required none",
                             data_result, cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, data_result, e.res);
                    chk1({e.name, "_exc"}, data_exception, e.exc);
                    chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                    chk1({e.name, "_busy_at_rdy"}, busy, 1'b1);
                end
            end
        end
    end

    // Caller is at a negedge; the next posedge is the start edge. Returns one cycle later.
    task automatic start_op(input string nm, input logic m, input logic d,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res, input logic exc, input bit expect_rdy);
        exp_t e;
        c_mult = m;
        c_div  = d;
        op_a   = a;
        op_b   = b;
        if (expect_rdy) begin
            e.name = nm;
            e.res  = res;
            e.exc  = exc;
            e.cyc  = cyc + 34;
            sb.push_back(e);
        end
        @(negedge clk);
        c_mult = 1'b0;
        c_div  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d results pending, required 0", nm, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_result"}, data_result, 32'h0);
        chk1({nm, "_exc"}, data_exception, 1'b0);
        chk1({nm, "_rdy"}, data_resultRDY, 1'b0);
        chk1({nm, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        c_mult = 1'b0;
        c_div  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        start_op("mul_7_m6", 1, 0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 0, 1);
        chk1("busy_after_start", busy, 1'b1);
        wait_drain("mul_7_m6");
        chk1("busy_after_done", busy, 1'b0);
        chk1("rdy_after_done", data_resultRDY, 1'b0);

        start_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1, 1);
        wait_drain("mul_ovf");
        start_op("mul_min_1", 1, 0, 32'h8000_0000, 32'd1, 32'h8000_0000, 0, 1);
        wait_drain("mul_min_1");

        start_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 1);
        wait_drain("div_m7_2");
        start_op("div_5_0", 0, 1, 32'd5, 32'd0, 32'h0, 1, 1);
        wait_drain("div_5_0");

        start_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        wait_drain("div_min_m1");
        start_op("mul_min_m1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        wait_drain("mul_min_m1");

        start_op("mul_3_4", 1, 0, 32'd3, 32'd4, 32'd12, 0, 1);
        repeat (9) @(negedge clk);
        c_div = 1'b1;
        op_a  = 32'd1000;
        op_b  = 32'd10;
        @(negedge clk);
        c_div = 1'b0;
        wait_drain("mul_3_4");

        start_op("both_6_3", 1, 1, 32'd6, 32'd3, 32'd18, 0, 1);
        wait_drain("both_6_3");

        start_op("mul_abort", 1, 0, 32'd5, 32'd5, 32'd25, 0, 0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("mid_reset");
        rst = 1'b0;
        start_op("div_100_7", 0, 1, 32'd100, 32'd7, 32'd14, 0, 1);
        wait_drain("div_100_7");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
